// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder and its users.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one combinational read port.
module inst_mem_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The parent registers this at capture, so a same-edge write is seen as the old value.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_mem_responder.sv
// Memory end of the fetch path: accepts one PC request, returns the instruction word
// LATENCY cycles later with an error flag for misaligned or out-of-range addresses.
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int unsigned AW          = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);
    localparam logic [63:0] DEPTH_BYTES = 64'(DEPTH) * 64'd4;

    // Handshake: a transfer happens on any rising edge where valid and ready are both high;
    // valid never depends on ready, and ready here depends only on the FSM state.

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q;
    logic        accept;
    logic        capture;

    logic [63:0] cap_addr;
    logic [63:0] cap_off;
    logic        cap_err;
    logic [AW-1:0] cap_idx;
    logic [31:0] rd_data;

    logic [31:0] inst_q;
    logic        err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        capture   = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // With LATENCY==1 the capture happens on the acceptance edge, before addr_q is loaded.
    assign cap_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign cap_off  = cap_addr - BASE_ADDR;
    assign cap_err  = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR) || (cap_off >= DEPTH_BYTES);
    assign cap_idx  = cap_off[AW+1:2];

    inst_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (cap_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 64'd0;
            inst_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (capture) begin
                err_q  <= cap_err;
                inst_q <= cap_err ? 32'd0 : rd_data;
            end
        end
    end

    assign rsp_inst = inst_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: a LATENCY=2 instance for most scenarios, a LATENCY=3
// instance for the early-load case; both share clock, reset and the load port.
module tb_inst_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [63:0] req_addr;
    logic [31:0] rsp_inst;
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [63:0] req_addr3;
    logic [31:0] rsp_inst3;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic [32:0] exp_q[$];
    logic [31:0] mdl [0:DEPTH-1];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_inst(rsp_inst3), .rsp_err(rsp_err3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Reference: {err, inst} for an address against the model memory.
    function automatic logic [32:0] exp_of(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00 || a < BASE || off >= 64'(4 * DEPTH)) return {1'b1, 32'h0};
        return {1'b0, mdl[off[11:2]]};
    endfunction

    task automatic load_word(input int idx, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 10'(idx); ld_data = d;
        mdl[idx] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Drives one request on the LATENCY=2 instance; returns at the first negedge with rsp_valid.
    task automatic issue(input logic [63:0] a, output int lat, output logic [32:0] got);
        int guard;
        guard = 0;
        req_valid = 1'b1; req_addr = a;
        while (!req_ready && guard < 20) begin
            @(negedge clk); guard++;
        end
        exp_q.push_back(exp_of(a));
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk); lat++;
        end
        got = {rsp_err, rsp_inst};
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_inst !== 32'h0) begin n_err++; $display("FAIL reset_rsp_inst: got %h want 0", rsp_inst); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_basic();
        int lat;
        logic [32:0] got, exp;
        logic [63:0] addrs [2];
        load_word(0, 32'h0000_0413);
        load_word(1, 32'h0010_0513);
        addrs = '{BASE + 64'd4, BASE};
        for (int i = 0; i < 2; i++) begin
            issue(addrs[i], lat, got);
            exp = exp_q.pop_front();
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [32:0] got, exp;
        logic [63:0] addrs [5];
        logic        errs  [5];
        load_word(1023, 32'h00C0_0E13);
        addrs = '{BASE + 64'd2, 64'h0000_0000_7FFF_FFFC, BASE + 64'(4 * DEPTH),
                  BASE + 64'(4 * (DEPTH - 1)), 64'hFFFF_FFFF_FFFF_FFFC};
        errs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            issue(addrs[i], lat, got);
            exp = exp_q.pop_front();
            n_cmp++; if (got[32] !== errs[i]) begin n_err++; $display("FAIL err_flag[%0d]: got %b want %b", i, got[32], errs[i]); end
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL err_data[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [32:0] got, got2, exp;
        rsp_ready = 1'b0;
        issue(BASE, lat, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL stall_data: got %h want %h", got, exp); end
        req_valid = 1'b1; req_addr = BASE + 64'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, rsp_valid); end
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); end
            n_cmp++; if ({rsp_err, rsp_inst} !== exp) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, {rsp_err, rsp_inst}, exp); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", req_ready); end
        exp_q.push_back(exp_of(BASE + 64'd4));
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk); lat++;
        end
        got2 = {rsp_err, rsp_inst};
        exp = exp_q.pop_front();
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL stall_next_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (got2 !== exp) begin n_err++; $display("FAIL stall_next_data: got %h want %h", got2, exp); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [4];
        int          acc_cyc [4];
        int          n_sent, n_got, guard;
        logic [32:0] exp;
        load_word(2, 32'h0020_0593);
        load_word(3, 32'h00B5_0633);
        addrs = '{BASE, BASE + 64'd4, BASE + 64'd8, BASE + 64'd12};
        n_sent = 0; n_got = 0; guard = 0;
        rsp_ready = 1'b1;
        while ((n_sent < 4 || n_got < 4) && guard < 60) begin
            if (rsp_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
                n_cmp++; if ({rsp_err, rsp_inst} !== exp) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", n_got, {rsp_err, rsp_inst}, exp); end
                n_got++;
            end
            if (req_ready && n_sent < 4) begin
                req_valid = 1'b1; req_addr = addrs[n_sent];
                exp_q.push_back(exp_of(addrs[n_sent]));
                acc_cyc[n_sent] = cyc;
                n_sent++;
            end else if (n_sent == 4) begin
                req_valid = 1'b0;
            end
            @(negedge clk); guard++;
        end
        req_valid = 1'b0;
        n_cmp++; if (n_got !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", n_got); end
        for (int i = 1; i < n_sent; i++) begin
            n_cmp++; if (acc_cyc[i] - acc_cyc[i-1] !== LAT + 1) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], LAT + 1); end
        end
    endtask

    task automatic test_capture_load();
        int lat;
        logic [32:0] got, exp;
        load_word(5, 32'h1111_2222);
        req_valid = 1'b1; req_addr = BASE + 64'd20;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL capld_ready: got %b want 1", req_ready); end
        exp_q.push_back(exp_of(BASE + 64'd20));
        @(negedge clk);
        req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_en = 1'b0;
        mdl[5] = 32'hDEAD_BEEF;
        exp = exp_q.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL capld_valid: got %b want 1", rsp_valid); end
        n_cmp++; if ({rsp_err, rsp_inst} !== exp) begin n_err++; $display("FAIL capld_old: got %h want %h", {rsp_err, rsp_inst}, exp); end
        @(negedge clk);
        issue(BASE + 64'd20, lat, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== {1'b0, 32'hDEAD_BEEF} || got !== exp) begin n_err++; $display("FAIL capld_after: got %h want %h", got, exp); end
    endtask

    task automatic test_early_load();
        logic [32:0] exp;
        load_word(6, 32'h3333_4444);
        req_valid3 = 1'b1; req_addr3 = BASE + 64'd24;
        n_cmp++; if (req_ready3 !== 1'b1) begin n_err++; $display("FAIL early_ready: got %b want 1", req_ready3); end
        @(negedge clk);
        req_valid3 = 1'b0;
        ld_en = 1'b1; ld_addr = 10'd6; ld_data = 32'hDEAD_BEEF;
        mdl[6] = 32'hDEAD_BEEF;
        exp_q.push_back(exp_of(BASE + 64'd24));
        @(negedge clk);
        ld_en = 1'b0;
        n_cmp++; if (rsp_valid3 !== 1'b0) begin n_err++; $display("FAIL early_wait_valid: got %b want 0", rsp_valid3); end
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++; if (rsp_valid3 !== 1'b1) begin n_err++; $display("FAIL early_valid: got %b want 1", rsp_valid3); end
        n_cmp++; if ({rsp_err3, rsp_inst3} !== exp) begin n_err++; $display("FAIL early_new: got %h want %h", {rsp_err3, rsp_inst3}, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        logic [32:0] got, exp;
        logic        saw;
        load_word(7, 32'h0070_0713);
        req_valid = 1'b1; req_addr = BASE + 64'd28;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstwait_valid: got %b want 0", rsp_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL rstwait_stale: got %b want 0", saw); end
        issue(BASE + 64'd28, lat, got);
        exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstwait_preserved: got %h want %h", got, exp); end
        n_cmp++; if (got[31:0] !== 32'h0070_0713) begin n_err++; $display("FAIL rstwait_const: got %h want 00700713", got[31:0]); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = 64'd0; rsp_ready = 1'b1;
        req_valid3 = 1'b0; req_addr3 = 64'd0; rsp_ready3 = 1'b1;
        ld_en = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        @(negedge clk);
        test_errors();
        @(negedge clk);
        test_stall();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_capture_load();
        @(negedge clk);
        test_early_load();
        test_reset_mid_wait();
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
